// File: rtl/strobe_pkg.sv
// Shared types and helpers for the multi-channel strobe generator.
// The board clock frequency lives here so every build derives the prescaler divide the same way.
package strobe_pkg;

  typedef enum logic {STB_PERIODIC = 1'b0, STB_ONESHOT = 1'b1} stb_mode_e;
  typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} ch_state_e;

  localparam int BOARD_CLK_MHZ = 1;

  // Returns 0 for a nonsensical tick rate so the top level can flag it at elaboration.
  function automatic int calc_tick_div(input int board_clk_mhz, input int tick_hz);
    if (tick_hz <= 0) return 0;
    return (board_clk_mhz * 1_000_000) / tick_hz;
  endfunction

endpackage

// File: rtl/strobe_chan.sv
// One strobe channel: counts prescaler ticks up to a latched period and emits a
// one-clock strobe, either free-running or as a retriggerable one-shot.
module strobe_chan
  import strobe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             start_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             strobe_o,
  output logic             busy_o
);

  ch_state_e        state_q, state_d;
  stb_mode_e        mode_q, mode_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;
  logic             load_c;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    per_d    = per_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    load_c   = 1'b0;

    if (!en_i) begin
      state_d = CH_IDLE;
      cnt_d   = '0;
    end else if (start_i || (state_q == CH_IDLE && stb_mode_e'(mode_i) == STB_PERIODIC)) begin
      load_c = 1'b1;
    end else if (state_q == CH_RUN && tick_i) begin
      if (cnt_q == per_q - CNT_W'(1)) begin
        strobe_d = 1'b1;
        if (mode_q == STB_PERIODIC) begin
          load_c = 1'b1;
        end else begin
          state_d = CH_IDLE;
          cnt_d   = '0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A zero period parks the channel; a periodic channel retries auto-start next cycle.
    if (load_c) begin
      cnt_d   = '0;
      per_d   = period_i;
      mode_d  = stb_mode_e'(mode_i);
      state_d = (period_i == '0) ? CH_IDLE : CH_RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= CH_IDLE;
      mode_q   <= STB_PERIODIC;
      per_q    <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      per_q    <= per_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;
  assign busy_o   = (state_q == CH_RUN);

endmodule

// File: rtl/multi_strobe_gen.sv
// Multi-channel programmable strobe generator: a shared prescaler produces the
// base tick and N_CH independent channels count it to their own periods.
module multi_strobe_gen
  import strobe_pkg::*;
#(
  parameter int TICK_HZ = 1000,
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_CH-1:0]       en_i,
  input  logic [N_CH-1:0]       mode_i,
  input  logic [N_CH-1:0]       start_i,
  input  logic [N_CH*CNT_W-1:0] period_i,
  output logic                  tick_o,
  output logic [N_CH-1:0]       strobe_o,
  output logic [N_CH-1:0]       busy_o
);

  localparam int TICK_DIV = calc_tick_div(BOARD_CLK_MHZ, TICK_HZ);
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("multi_strobe_gen: TICK_DIV must be >= 1 (check TICK_HZ vs BOARD_CLK_MHZ)");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("multi_strobe_gen: N_CH must be in 1..16");
  end

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick_c;

  // With a divide of one PRE_LAST is zero, so the tick is held high permanently.
  assign tick_c    = (pre_cnt_q == PRE_LAST);
  assign pre_cnt_d = tick_c ? '0 : pre_cnt_q + PRE_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  assign tick_o = tick_c;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    strobe_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en_i[gi]),
      .mode_i  (mode_i[gi]),
      .start_i (start_i[gi]),
      .tick_i  (tick_c),
      .period_i(period_i[gi*CNT_W +: CNT_W]),
      .strobe_o(strobe_o[gi]),
      .busy_o  (busy_o[gi])
    );
  end

endmodule

// File: tb/tb_multi_strobe_gen.sv
// Self-checking bench: expected strobe cycles are queued per phase and matched against DUT output each cycle.
module tb_multi_strobe_gen;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic [N_CH-1:0]       en_i, mode_i, start_i;
  logic [N_CH*CNT_W-1:0] period_i;
  logic                  tick_o;
  logic [N_CH-1:0]       strobe_o, busy_o;

  logic                  en1_i, mode1_i, start1_i;
  logic [7:0]            period1_i;
  logic                  tick1_o, strobe1_o, busy1_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  multi_strobe_gen #(.TICK_HZ(250_000), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .mode_i(mode_i), .start_i(start_i),
    .period_i(period_i), .tick_o(tick_o), .strobe_o(strobe_o), .busy_o(busy_o)
  );

  multi_strobe_gen #(.TICK_HZ(1_000_000), .N_CH(1), .CNT_W(8)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en1_i), .mode_i(mode1_i), .start_i(start1_i),
    .period_i(period1_i), .tick_o(tick1_o), .strobe_o(strobe1_o), .busy_o(busy1_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_period(input int ch, input int p);
    period_i[ch*CNT_W +: CNT_W] = CNT_W'(p);
  endtask

  task automatic push_exp(input int c, input int ch);
    exp_q.push_back(c * 16 + ch);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst_i = 1'b0;
    cyc   = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic check_cycle(input logic [N_CH-1:0] busy_exp);
    logic exp_bit;
    @(negedge clk);
    chk("tick", int'(tick_o), int'(cyc % 4 == 3));
    for (int ch = 0; ch < N_CH; ch++) begin
      exp_bit = (exp_q.size() > 0) && (exp_q[0] == cyc * 16 + ch);
      if (exp_bit) void'(exp_q.pop_front());
      if (strobe_o[ch]) $display("cyc=%0d ch%0d strobe (expected=%0d)", cyc, ch, exp_bit);
      chk($sformatf("strobe%0d", ch), int'(strobe_o[ch]), int'(exp_bit));
      chk($sformatf("busy%0d", ch), int'(busy_o[ch]), int'(busy_exp[ch]));
    end
    chk("tick1", int'(tick1_o), 1);
    chk("strobe1", int'(strobe1_o), int'(cyc >= 6 && (cyc - 6) % 5 == 0));
    chk("busy1", int'(busy1_o), int'(cyc >= 1));
  endtask

  initial begin
    rst_i     = 1'b1;
    en_i      = '0;
    mode_i    = '0;
    start_i   = '0;
    period_i  = '0;
    en1_i     = 1'b1;
    mode1_i   = 1'b0;
    start1_i  = 1'b0;
    period1_i = 8'd5;

    // Periodic ch0, one-shot ch1, zero-period then reloaded ch2.
    apply_reset();
    en_i   = 4'b0111;
    mode_i = 4'b0010;
    set_period(0, 3);
    set_period(1, 2);
    set_period(2, 0);
    set_period(3, 0);
    for (int k = 1; k <= 11; k++) push_exp(12 * k, 0);
    push_exp(8, 1);
    push_exp(104, 2); push_exp(108, 2); push_exp(112, 2); push_exp(116, 2);
    push_exp(124, 2); push_exp(132, 2); push_exp(140, 2);
    exp_q.sort();
    release_reset();
    while (cyc <= 140) begin
      start_i = (cyc == 1) ? 4'b0010 : 4'b0000;
      if (cyc == 100) set_period(2, 1);
      if (cyc == 114) set_period(2, 2);
      check_cycle({1'b0, cyc >= 101, cyc >= 2 && cyc <= 7, cyc >= 1});
      next_cycle();
    end

    // Disable/re-enable ch0, start on the fire cycle for ch3, then reset mid-run.
    apply_reset();
    en_i   = 4'b1001;
    mode_i = 4'b0000;
    set_period(0, 3);
    set_period(1, 0);
    set_period(2, 0);
    set_period(3, 2);
    push_exp(20, 0); push_exp(32, 0); push_exp(44, 0);
    push_exp(8, 3); push_exp(24, 3); push_exp(32, 3); push_exp(40, 3); push_exp(48, 3);
    exp_q.sort();
    release_reset();
    while (cyc <= 55) begin
      en_i[0] = !(cyc == 8 || cyc == 9);
      start_i = (cyc == 15) ? 4'b1000 : 4'b0000;
      rst_i   = (cyc == 55);
      check_cycle({cyc >= 1, 1'b0, 1'b0, cyc >= 1 && !(cyc == 9 || cyc == 10)});
      next_cycle();
    end

    // One reset cycle has been sampled; the strobes due at the next cycle must be gone.
    push_exp(12, 0); push_exp(24, 0);
    push_exp(8, 3); push_exp(16, 3); push_exp(24, 3);
    exp_q.sort();
    release_reset();
    while (cyc <= 30) begin
      check_cycle({cyc >= 1, 1'b0, 1'b0, cyc >= 1});
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
